// File: rtl/snitch_icache_pkg.sv
`default_nettype none
// ============================================================================
// Package     : snitch_icache_pkg
// Description : Shared instruction-cache configuration, refill constants and
//               the refill back-end state type.
// Revision    : 1.0 - initial release
// ============================================================================
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned FETCH_AW;
    int unsigned LINE_WIDTH;
    int unsigned BEAT_WIDTH;
    int unsigned PENDING_IW;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    FETCH_AW:   32,
    LINE_WIDTH: 128,
    BEAT_WIDTH: 32,
    PENDING_IW: 2
  };

  localparam int unsigned NUM_BEATS  = DEFAULT_CFG.LINE_WIDTH / DEFAULT_CFG.BEAT_WIDTH;
  localparam int unsigned BEAT_ALIGN = $clog2(DEFAULT_CFG.BEAT_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } refill_state_e;

  function automatic int unsigned beats_per_line(input config_t cfg);
    return cfg.LINE_WIDTH / cfg.BEAT_WIDTH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snitch_icache_line_assembler_if.sv
`default_nettype none
// ============================================================================
// Interface   : snitch_icache_line_assembler_if
// Description : Refill request/response port plus narrow memory read port of
//               the line assembler. Directions are named from the assembler.
// Revision    : 1.0 - initial release
// ============================================================================
interface snitch_icache_line_assembler_if #(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH = 32,
  parameter int unsigned PENDING_IW = 2
);

  logic [FETCH_AW-1:0]   in_req_addr_i;
  logic [PENDING_IW-1:0] in_req_id_i;
  logic                  in_req_valid_i;
  logic                  in_req_ready_o;

  logic [LINE_WIDTH-1:0] in_rsp_data_o;
  logic                  in_rsp_error_o;
  logic [PENDING_IW-1:0] in_rsp_id_o;
  logic                  in_rsp_valid_o;
  logic                  in_rsp_ready_i;

  logic                  mem_req_o;
  logic [FETCH_AW-1:0]   mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [BEAT_WIDTH-1:0] mem_rdata_i;
  logic                  mem_rerr_i;

  // Assembler side.
  modport slave (
    input  in_req_addr_i, in_req_id_i, in_req_valid_i,
    output in_req_ready_o,
    output in_rsp_data_o, in_rsp_error_o, in_rsp_id_o, in_rsp_valid_o,
    input  in_rsp_ready_i,
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_rerr_i
  );

  // Environment side: miss handler and memory.
  modport master (
    output in_req_addr_i, in_req_id_i, in_req_valid_i,
    input  in_req_ready_o,
    input  in_rsp_data_o, in_rsp_error_o, in_rsp_id_o, in_rsp_valid_o,
    output in_rsp_ready_i,
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_rerr_i
  );

endinterface
`default_nettype wire

// File: rtl/snitch_icache_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : snitch_icache_line_assembler
// Description : Splits one line refill into narrow in-order memory reads and
//               assembles the returned beats into a full cache line.
// Revision    : 1.0 - initial release
// ============================================================================
module snitch_icache_line_assembler
  import snitch_icache_pkg::*;
#(
  parameter int unsigned FETCH_AW   = DEFAULT_CFG.FETCH_AW,
  parameter int unsigned LINE_WIDTH = DEFAULT_CFG.LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH = DEFAULT_CFG.BEAT_WIDTH,
  parameter int unsigned PENDING_IW = DEFAULT_CFG.PENDING_IW
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  snitch_icache_line_assembler_if.slave bus
);

  localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_WIDTH / 8);
  localparam int unsigned CNT_W      = $clog2(BEATS) + 1;

  localparam logic [FETCH_AW-1:0] LINE_MASK =
    ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

  refill_state_e         r_state;
  refill_state_e         w_state_next;
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [CNT_W-1:0]      r_recv_cnt;
  logic [FETCH_AW-1:0]   r_base;
  logic [PENDING_IW-1:0] r_id;
  logic                  r_err;
  logic [LINE_WIDTH-1:0] r_line;

  logic                  w_req_hs;
  logic                  w_mem_req;
  logic                  w_issue;
  logic                  w_beat_ok;
  logic                  w_last_beat;
  logic [BEATS-1:0]      w_beat_we;

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  assign w_req_hs    = (r_state == IDLE) && bus.in_req_valid_i;
  assign w_mem_req   = (r_state == FETCH) && (r_issue_cnt < CNT_W'(BEATS));
  assign w_issue     = w_mem_req && bus.mem_gnt_i;
  // Beats arriving outside FETCH or ahead of their grant are dropped.
  assign w_beat_ok   = (r_state == FETCH) && bus.mem_rvalid_i && (r_recv_cnt < r_issue_cnt);
  assign w_last_beat = w_beat_ok && (r_recv_cnt == CNT_W'(BEATS - 1));

  // --------------------------------------------------------------------------
  // Refill FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_req_valid_i) w_state_next = FETCH;
      FETCH:   if (w_last_beat)        w_state_next = RESP;
      RESP:    if (bus.in_rsp_ready_i) w_state_next = IDLE;
      default:                         w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture, beat counters and error accumulation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base      <= '0;
      r_id        <= '0;
      r_err       <= 1'b0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (w_req_hs) begin
      r_base      <= bus.in_req_addr_i & LINE_MASK;
      r_id        <= bus.in_req_id_i;
      r_err       <= 1'b0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      // w_issue implies issue_cnt < BEATS, so the counter stops at BEATS.
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_beat_ok) begin
        r_recv_cnt <= r_recv_cnt + CNT_W'(1);
        r_err      <= r_err | bus.mem_rerr_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line register, one write enable per beat slot
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < BEATS; b++) begin : g_beat_we
    assign w_beat_we[b] = w_beat_ok && (r_recv_cnt == CNT_W'(b));
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BEATS; b++) begin
      if (w_beat_we[b]) begin
        r_line[b*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rdata_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_req_ready_o = (r_state == IDLE);
  assign bus.in_rsp_valid_o = (r_state == RESP);
  assign bus.in_rsp_data_o  = r_line;
  assign bus.in_rsp_error_o = r_err;
  assign bus.in_rsp_id_o    = r_id;

  assign bus.mem_req_o      = w_mem_req;
  assign bus.mem_addr_o     = r_base + (FETCH_AW'(r_issue_cnt) << BEAT_SHIFT);

  // A read beat is only legal for a granted, not yet returned request.
  a_rvalid_in_flight : assert property (
    @(posedge clk_i) disable iff (rst_i)
    bus.mem_rvalid_i |-> ((r_state == FETCH) && (r_recv_cnt < r_issue_cnt))
  );

endmodule
`default_nettype wire

// File: tb/tb_snitch_icache_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_snitch_icache_line_assembler
// Description : Self-checking bench with a behavioural memory and line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snitch_icache_line_assembler;

  localparam int unsigned AW   = 32;
  localparam int unsigned LW   = 128;
  localparam int unsigned BW   = 32;
  localparam int unsigned IW   = 2;
  localparam int unsigned NB   = LW / BW;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0]  addr;
    logic [1:0]   id;
    int           hold;
    logic [31:0]  err_addr;
    logic [31:0]  stall_addr;
    int           stall;
    bit           chk_lat;
    logic [127:0] exp_line;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_grants = 0;

  logic [31:0] err_addr   = NONE;
  logic [31:0] stall_addr = NONE;
  int          stall_left = 0;
  bit          stall_armed = 1'b0;
  bit          rand_mode = 1'b0;
  beat_t       mq[$];

  snitch_icache_line_assembler_if #(
    .FETCH_AW(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .PENDING_IW(IW)
  ) bus ();

  snitch_icache_line_assembler #(
    .FETCH_AW(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .PENDING_IW(IW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Reference model: memory contents and expected line/error per refill
  // --------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1010) return 32'hA + ((a - 32'h1000) >> 2);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = a & ~32'hF;
    l = '0;
    for (int k = 0; k < NB; k++) l = l | (128'(mem_word(base + 32'(4 * k))) << (32 * k));
    return l;
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic [31:0] ea);
    return (ea != NONE) && ((ea & ~32'hF) == (a & ~32'hF));
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  // --------------------------------------------------------------------------
  // Memory: in-order, grant-to-rvalid delay 0 (one-cycle) or random 0-4
  // --------------------------------------------------------------------------
  initial begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_rerr_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
      end else begin
        if (bus.mem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
        if (bus.mem_req_o && bus.mem_gnt_i) begin
          mq.push_back('{addr: bus.mem_addr_o,
                         due: cyc + 1 + (rand_mode ? int'($urandom_range(0, 4)) : 0)});
          n_grants++;
        end
      end
      @(posedge clk);
      #2;
      bus.mem_gnt_i = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall_left > 0 && bus.mem_req_o && (stall_armed || bus.mem_addr_o == stall_addr)) begin
        if (stall_armed) chk("stall_addr", 128'(bus.mem_addr_o), 128'(stall_addr));
        stall_armed   = 1'b1;
        bus.mem_gnt_i = 1'b0;
        stall_left--;
      end else begin
        stall_armed = 1'b0;
      end
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = mem_word(mq[0].addr);
        bus.mem_rerr_i   = (mq[0].addr == err_addr);
      end else begin
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        bus.mem_rerr_i   = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // One refill: request, await response, hold it, consume it
  // --------------------------------------------------------------------------
  task automatic run_refill(input vec_t v, input string tag);
    int t;
    int h;
    int g0;
    err_addr    = v.err_addr;
    stall_addr  = v.stall_addr;
    stall_left  = v.stall;
    bus.in_req_addr_i  = v.addr;
    bus.in_req_id_i    = v.id;
    bus.in_req_valid_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.in_req_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      timeout({tag, ".req"});
      bus.in_req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    h  = cyc;
    g0 = n_grants;
    bus.in_req_valid_i = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.in_rsp_valid_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      timeout({tag, ".rsp"});
      return;
    end
    if (v.chk_lat) chk({tag, ".latency"}, 128'(cyc - h), 128'(NB + 1));
    chk({tag, ".data"},   bus.in_rsp_data_o,         v.exp_line);
    chk({tag, ".error"},  128'(bus.in_rsp_error_o),  128'(v.exp_err));
    chk({tag, ".id"},     128'(bus.in_rsp_id_o),     128'(v.id));
    chk({tag, ".beats"},  128'(n_grants - g0),       128'(NB));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 128'(bus.in_rsp_valid_o), 128'(1));
      chk({tag, ".hold_data"},  bus.in_rsp_data_o,        v.exp_line);
      chk({tag, ".hold_id"},    128'(bus.in_rsp_id_o),    128'(v.id));
      chk({tag, ".hold_ready"}, 128'(bus.in_req_ready_o), 128'(0));
    end
    bus.in_rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_rsp_ready_i = 1'b0;
    chk({tag, ".after_valid"}, 128'(bus.in_rsp_valid_o), 128'(0));
    chk({tag, ".after_ready"}, 128'(bus.in_req_ready_o), 128'(1));
  endtask

  vec_t tbl[5];
  vec_t sb[$];

  initial begin
    int n;
    int t;
    vec_t v;
    logic [31:0] a;

    tbl[0] = '{addr: 32'h1004, id: 2'd2, hold: 0, err_addr: NONE, stall_addr: NONE, stall: 0,
               chk_lat: 1'b1, exp_line: 128'h0000000D_0000000C_0000000B_0000000A, exp_err: 1'b0};
    tbl[1] = '{addr: 32'h100C, id: 2'd1, hold: 0, err_addr: NONE, stall_addr: 32'h1004, stall: 3,
               chk_lat: 1'b0, exp_line: 128'h0000000D_0000000C_0000000B_0000000A, exp_err: 1'b0};
    tbl[2] = '{addr: 32'h2008, id: 2'd3, hold: 0, err_addr: 32'h2008, stall_addr: NONE, stall: 0,
               chk_lat: 1'b1, exp_line: ref_line(32'h2000), exp_err: 1'b1};
    tbl[3] = '{addr: 32'h2000, id: 2'd0, hold: 0, err_addr: NONE, stall_addr: NONE, stall: 0,
               chk_lat: 1'b1, exp_line: ref_line(32'h2000), exp_err: 1'b0};
    tbl[4] = '{addr: 32'h4444, id: 2'd2, hold: 5, err_addr: NONE, stall_addr: NONE, stall: 0,
               chk_lat: 1'b1, exp_line: ref_line(32'h4440), exp_err: 1'b0};

    bus.in_req_addr_i  = '0;
    bus.in_req_id_i    = '0;
    bus.in_req_valid_i = 1'b0;
    bus.in_rsp_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", 128'(bus.in_req_ready_o), 128'(1));
    chk("reset.rsp_valid", 128'(bus.in_rsp_valid_o), 128'(0));
    chk("reset.mem_req",   128'(bus.mem_req_o),      128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) run_refill(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a refill, after two beats have returned.
    bus.in_req_addr_i  = 32'h3000;
    bus.in_req_id_i    = 2'd1;
    bus.in_req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_req_valid_i = 1'b0;
    n = 0;
    t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk);
      if (bus.mem_rvalid_i) n++;
      t++;
    end
    if (n < 2) timeout("midreset.beats");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset.rsp_valid", 128'(bus.in_rsp_valid_o), 128'(0));
    chk("midreset.mem_req",   128'(bus.mem_req_o),      128'(0));
    chk("midreset.req_ready", 128'(bus.in_req_ready_o), 128'(1));
    rst = 1'b0;
    v = tbl[0];
    v.addr = 32'h1000;
    v.id   = 2'd1;
    run_refill(v, "postreset");

    // Back-to-back refills with random grant and return delays.
    rand_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      v.addr       = a;
      v.id         = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : (i == 2) ? 2'd3 : 2'($urandom_range(0, 3));
      v.hold       = $urandom_range(0, 2);
      v.err_addr   = ($urandom_range(0, 2) == 0) ? ((a & ~32'hF) + 32'(4 * $urandom_range(0, 3))) : NONE;
      v.stall_addr = NONE;
      v.stall      = 0;
      v.chk_lat    = 1'b0;
      v.exp_line   = ref_line(a);
      v.exp_err    = ref_err(a, v.err_addr);
      sb.push_back(v);
    end
    while (sb.size() > 0) begin
      v = sb.pop_front();
      run_refill(v, $sformatf("rand_id%0d", v.id));
    end
    rand_mode = 1'b0;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
